// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: counters out to the
// colour/address stage, colour back in, registered pixel/sync to the pins.
// Optional macro: VGA_TEST_PATTERN_EN adds the test_en select.
interface vga_timing_gen_if;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic [14:0] color_in;
  logic [4:0]  vga_r;
  logic [4:0]  vga_g;
  logic [4:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic        vblank;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_en;

  modport master (
    output sx, sy, vga_r, vga_g, vga_b, hsync, vsync, de, frame_start, vblank,
    input  color_in, test_en
  );

  modport slave (
    input  sx, sy, vga_r, vga_g, vga_b, hsync, vsync, de, frame_start, vblank,
    output color_in, test_en
  );
`else
  modport master (
    output sx, sy, vga_r, vga_g, vga_b, hsync, vsync, de, frame_start, vblank,
    input  color_in
  );

  modport slave (
    input  sx, sy, vga_r, vga_g, vga_b, hsync, vsync, de, frame_start, vblank,
    output color_in
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running sx/sy counters, sync/enable decode,
// a RAM_LATENCY-deep delay line matching the colour lookup, and a final
// output register so RGB, sync and de leave together.
// Optional macro: VGA_TEST_PATTERN_EN adds an eight-bar colour test pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 48,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 13,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 32,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int RAM_LATENCY = 1
) (
  input logic             clk,
  input logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [9:0]  sx_q, sx_d;
  logic [9:0]  sy_q, sy_d;
  logic        de0, hs0, vs0;
  logic [2:0]  ctlDly_q [RAM_LATENCY];
  logic [2:0]  ctlLast;
  logic        de_q, hs_q, vs_q;
  logic [14:0] rgb_q;
  logic [14:0] pixSrc;

  // Next counter values: sx wraps every line, sy steps only on that wrap
  always_comb begin
    sx_d = sx_q + 10'd1;
    sy_d = sy_q;
    if (sx_q == 10'(H_TOTAL - 1)) begin
      sx_d = 10'd0;
      sy_d = (sy_q == 10'(V_TOTAL - 1)) ? 10'd0 : sy_q + 10'd1;
    end
  end

  // Counter registers; reset parks both at the frame origin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q <= 10'd0;
      sy_q <= 10'd0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  // Stage-0 decode of enable and sync windows straight from the counters
  always_comb begin
    de0 = (sx_q < 10'(H_ACTIVE)) && (sy_q < 10'(V_ACTIVE));
    hs0 = ((sx_q >= 10'(HS_FIRST)) && (sx_q <= 10'(HS_LAST))) ? H_POL : ~H_POL;
    vs0 = ((sy_q >= 10'(VS_FIRST)) && (sy_q <= 10'(VS_LAST))) ? V_POL : ~V_POL;
  end

  // Delay line holding {de, hsync, vsync} while the colour stage looks up the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) ctlDly_q[i] <= {1'b0, ~H_POL, ~V_POL};
    end else begin
      ctlDly_q[0] <= {de0, hs0, vs0};
      for (int i = 1; i < RAM_LATENCY; i++) ctlDly_q[i] <= ctlDly_q[i-1];
    end
  end

  assign ctlLast = ctlDly_q[RAM_LATENCY-1];

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]  sxDly_q [RAM_LATENCY];
  logic [9:0]  barX;
  logic [14:0] barColor;

  // sx delayed alongside the control bits so the bars line up like color_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) sxDly_q[i] <= 10'd0;
    end else begin
      sxDly_q[0] <= sx_q;
      for (int i = 1; i < RAM_LATENCY; i++) sxDly_q[i] <= sxDly_q[i-1];
    end
  end

  assign barX = sxDly_q[RAM_LATENCY-1];

  // Eight 100-pixel bars: white, yellow, cyan, green, magenta, red, blue, black
  always_comb begin
    barColor = 15'h0000;
    if      (barX < 10'd100) barColor = 15'h7FFF;
    else if (barX < 10'd200) barColor = 15'h7FE0;
    else if (barX < 10'd300) barColor = 15'h03FF;
    else if (barX < 10'd400) barColor = 15'h03E0;
    else if (barX < 10'd500) barColor = 15'h7C1F;
    else if (barX < 10'd600) barColor = 15'h7C00;
    else if (barX < 10'd700) barColor = 15'h001F;
    else                     barColor = 15'h0000;
  end

  assign pixSrc = bus.test_en ? barColor : bus.color_in;
`else
  assign pixSrc = bus.color_in;
`endif

  // Output register: pixel shown only while the delayed enable is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      rgb_q <= 15'h0000;
    end else begin
      de_q  <= ctlLast[2];
      hs_q  <= ctlLast[1];
      vs_q  <= ctlLast[0];
      rgb_q <= ctlLast[2] ? pixSrc : 15'h0000;
    end
  end

  assign bus.sx          = sx_q;
  assign bus.sy          = sy_q;
  assign bus.vga_r       = rgb_q[14:10];
  assign bus.vga_g       = rgb_q[9:5];
  assign bus.vga_b       = rgb_q[4:0];
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.de          = de_q;
  assign bus.frame_start = rst_n && (sx_q == 10'd0) && (sy_q == 10'd0);
  assign bus.vblank      = (sy_q >= 10'(V_ACTIVE));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing is the default 976-clock
// line; the vertical frame is shortened to 8 lines so whole frames stay cheap.
module tb_vga_timing_gen;

  localparam int HT    = 976;
  localparam int VA    = 4;
  localparam int VFP   = 1;
  localparam int VSW   = 2;
  localparam int VBP   = 1;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic clk;
  logic rst_n;
  vga_timing_gen_if vif();

  int vectors;
  int miscompares;

  logic [1:0]  colorMode;
  logic [14:0] alignColor;

  logic [9:0] mSx, mSy, h1Sx, h2Sx, h1Sy, h2Sy;

  vga_timing_gen #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (vif)
  );

  // Pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Colour stage stand-in: registered copy of sx for the alignment test
  always @(posedge clk) alignColor <= {vif.sx[4:0], vif.sx[4:0], vif.sx[4:0]};

  assign vif.color_in = (colorMode == 2'd1) ? alignColor :
                        (colorMode == 2'd2) ? 15'h7FFF : 15'h2ACB;

  // Reference counter plus two-clock history for pin-level expectations
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSx <= '0; mSy <= '0; h1Sx <= '0; h2Sx <= '0; h1Sy <= '0; h2Sy <= '0;
    end else begin
      if (mSx == 10'(HT - 1)) begin
        mSx <= '0;
        mSy <= (mSy == 10'(VT - 1)) ? 10'd0 : mSy + 10'd1;
      end else begin
        mSx <= mSx + 10'd1;
      end
      h1Sx <= mSx; h2Sx <= h1Sx;
      h1Sy <= mSy; h2Sy <= h1Sy;
    end
  end

  function automatic logic expDe();
    return (h2Sx < 10'd800) && (h2Sy < 10'(VA));
  endfunction

  function automatic logic expHs();
    return !((h2Sx >= 10'd840) && (h2Sx <= 10'd887));
  endfunction

  function automatic logic expVs();
    return !((h2Sy >= 10'(VA + VFP)) && (h2Sy <= 10'(VA + VFP + VSW - 1)));
  endfunction

  // Reset values while rst_n is low, then frame_start on release
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (vif.sx !== 10'd0 || vif.sy !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters: sx=%0d sy=%0d, want 0/0", vif.sx, vif.sy);
    end
    vectors++;
    if (vif.de !== 1'b0 || {vif.vga_r, vif.vga_g, vif.vga_b} !== 15'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_pixel: de=%b rgb=%h, want 0/0", vif.de,
               {vif.vga_r, vif.vga_g, vif.vga_b});
    end
    vectors++;
    if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_sync: hs=%b vs=%b, want 1/1", vif.hsync, vif.vsync);
    end
    vectors++;
    if (vif.frame_start !== 1'b0 || vif.vblank !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: fs=%b vblank=%b, want 0/0", vif.frame_start, vif.vblank);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (vif.frame_start !== 1'b1 || vif.sx !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL release_start: fs=%b sx=%0d, want 1/0", vif.frame_start, vif.sx);
    end
  endtask

  // Counter walk over a full frame and frame_start period
  task automatic test_frame_timing();
    int n, bad, vbBad, fsBad;
    n = 0; bad = 0; vbBad = 0; fsBad = 0;
    do begin
      @(negedge clk);
      n++;
      if (vif.sx !== mSx || vif.sy !== mSy) bad++;
      if (vif.vblank !== (mSy >= 10'(VA))) vbBad++;
      if (vif.frame_start !== (mSx == 10'd0 && mSy == 10'd0)) fsBad++;
    end while (vif.frame_start !== 1'b1 && n < FRAME + 10);
    vectors++;
    if (n !== FRAME) begin
      miscompares++;
      $display("[TB] FAIL frame_period: got %0d clocks, want %0d", n, FRAME);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL counter_walk: %0d bad clocks, want 0", bad);
    end
    vectors++;
    if (vbBad !== 0) begin
      miscompares++;
      $display("[TB] FAIL vblank: %0d bad clocks, want 0", vbBad);
    end
    vectors++;
    if (fsBad !== 0) begin
      miscompares++;
      $display("[TB] FAIL frame_start_shape: %0d bad clocks, want 0", fsBad);
    end
  endtask

  // Pin-level sync/de windows and their widths over one frame
  task automatic test_sync();
    int hsBad, vsBad, deBad, rgbBad, hsLow, vsLow, deHigh;
    hsBad = 0; vsBad = 0; deBad = 0; rgbBad = 0; hsLow = 0; vsLow = 0; deHigh = 0;
    colorMode = 2'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (vif.hsync !== expHs()) hsBad++;
      if (vif.vsync !== expVs()) vsBad++;
      if (vif.de !== expDe()) deBad++;
      if ({vif.vga_r, vif.vga_g, vif.vga_b} !== (expDe() ? 15'h2ACB : 15'h0)) rgbBad++;
      if (vif.hsync === 1'b0) hsLow++;
      if (vif.vsync === 1'b0) vsLow++;
      if (vif.de === 1'b1) deHigh++;
    end
    vectors++;
    if (hsBad !== 0) begin
      miscompares++;
      $display("[TB] FAIL hsync_window: %0d bad clocks, want 0", hsBad);
    end
    vectors++;
    if (hsLow !== 48 * VT) begin
      miscompares++;
      $display("[TB] FAIL hsync_width: %0d low clocks, want %0d", hsLow, 48 * VT);
    end
    vectors++;
    if (vsBad !== 0 || vsLow !== VSW * HT) begin
      miscompares++;
      $display("[TB] FAIL vsync_window: bad=%0d low=%0d, want 0/%0d", vsBad, vsLow, VSW * HT);
    end
    vectors++;
    if (deBad !== 0 || deHigh !== 800 * VA) begin
      miscompares++;
      $display("[TB] FAIL de_window: bad=%0d high=%0d, want 0/%0d", deBad, deHigh, 800 * VA);
    end
    vectors++;
    if (rgbBad !== 0) begin
      miscompares++;
      $display("[TB] FAIL rgb_pass: %0d bad clocks, want 0", rgbBad);
    end
  endtask

  // Full-white input must appear only while de is high
  task automatic test_white();
    int bad, blankBad, whiteCnt;
    bad = 0; blankBad = 0; whiteCnt = 0;
    colorMode = 2'd2;
    repeat (3) @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if ({vif.vga_r, vif.vga_g, vif.vga_b} !== (expDe() ? 15'h7FFF : 15'h0)) bad++;
      if (h2Sx >= 10'd800 && {vif.vga_r, vif.vga_g, vif.vga_b} !== 15'h0) blankBad++;
      if ({vif.vga_r, vif.vga_g, vif.vga_b} === 15'h7FFF) whiteCnt++;
    end
    vectors++;
    if (bad !== 0 || whiteCnt !== 800 * VA) begin
      miscompares++;
      $display("[TB] FAIL white_gate: bad=%0d white=%0d, want 0/%0d", bad, whiteCnt, 800 * VA);
    end
    vectors++;
    if (blankBad !== 0) begin
      miscompares++;
      $display("[TB] FAIL blank_800_975: %0d lit clocks, want 0", blankBad);
    end
  endtask

  // color_in = sx pattern delayed one clock: first visible pixel 0, then 1, last 31
  task automatic test_alignment();
    int k;
    logic [4:0] lastR;
    colorMode = 2'd1;
    k = 0;
    while (vif.de !== 1'b0 && k < FRAME) begin @(negedge clk); k++; end
    while (vif.de !== 1'b1 && k < FRAME) begin @(negedge clk); k++; end
    vectors++;
    if (k >= FRAME) begin
      miscompares++;
      $display("[TB] FAIL align_wait: no de rise within %0d clocks", FRAME);
    end
    vectors++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 15'h0 || h2Sx !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL align_first: rgb=%h pinSx=%0d, want 0/0",
               {vif.vga_r, vif.vga_g, vif.vga_b}, h2Sx);
    end
    @(negedge clk);
    vectors++;
    if (vif.vga_r !== 5'd1 || vif.vga_g !== 5'd1 || vif.vga_b !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL align_second: r=%0d g=%0d b=%0d, want 1/1/1",
               vif.vga_r, vif.vga_g, vif.vga_b);
    end
    lastR = vif.vga_r;
    k = 0;
    while (vif.de === 1'b1 && k < HT) begin lastR = vif.vga_r; @(negedge clk); k++; end
    vectors++;
    if (lastR !== 5'd31 || k !== 799) begin
      miscompares++;
      $display("[TB] FAIL align_last: r=%0d run=%0d, want 31/799", lastR, k);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  // Test bars at pixels 0, 150, 450, 799 of a visible line
  task automatic test_pattern();
    int k;
    logic [9:0]  xs [4];
    logic [14:0] want [4];
    xs[0] = 10'd0;   want[0] = 15'h7FFF;
    xs[1] = 10'd150; want[1] = 15'h7FE0;
    xs[2] = 10'd450; want[2] = 15'h7C1F;
    xs[3] = 10'd799; want[3] = 15'h0000;
    vif.test_en = 1'b1;
    colorMode = 2'd0;
    k = 0;
    while (!(h2Sx == 10'd0 && h2Sy < 10'(VA)) && k < FRAME) begin @(negedge clk); k++; end
    for (int i = 0; i < 4; i++) begin
      while (h2Sx != xs[i] && k < FRAME) begin @(negedge clk); k++; end
      vectors++;
      if ({vif.vga_r, vif.vga_g, vif.vga_b} !== want[i] || k >= FRAME) begin
        miscompares++;
        $display("[TB] FAIL pattern_px%0d: rgb=%h, want %h", xs[i],
                 {vif.vga_r, vif.vga_g, vif.vga_b}, want[i]);
      end
    end
    vif.test_en = 1'b0;
  endtask
`endif

  // Reset inside the hsync pulse: sync releases at once, frame restarts clean
  task automatic test_reset_midline();
    int k, bad;
    colorMode = 2'd0;
    k = 0;
    while (mSx != 10'd860 && k < 2 * HT) begin @(negedge clk); k++; end
    vectors++;
    if (vif.hsync !== 1'b0 || k >= 2 * HT) begin
      miscompares++;
      $display("[TB] FAIL midline_pre: hs=%b, want 0", vif.hsync);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (vif.hsync !== 1'b1 || vif.sx !== 10'd0 || vif.frame_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midline_async: hs=%b sx=%0d fs=%b, want 1/0/0",
               vif.hsync, vif.sx, vif.frame_start);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (vif.frame_start !== 1'b1 || vif.sx !== 10'd0 || vif.sy !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL midline_restart: fs=%b sx=%0d sy=%0d, want 1/0/0",
               vif.frame_start, vif.sx, vif.sy);
    end
    @(negedge clk);
    vectors++;
    if (vif.sx !== 10'd1 || vif.frame_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midline_count: sx=%0d fs=%b, want 1/0", vif.sx, vif.frame_start);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (vif.hsync !== 1'b1) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL midline_no_extend: %0d low clocks, want 0", bad);
    end
  endtask

  // Hard stop if anything above stops making progress
  initial begin
    #(100000 * 10);
    $display("[TB] FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    colorMode = 2'd0;
    rst_n = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    vif.test_en = 1'b0;
`endif
    test_reset();
    test_frame_timing();
    test_sync();
    test_white();
    test_alignment();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
